// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_pc,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [1:0]  size;
      logic        sign;
      logic        we;
   } req_t;

   state_t      state, state_nxt;
   req_t        req_q;
   logic        misaligned;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   always_comb begin
      case (req_size)
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr[1:0] != 2'b00);
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Lane extraction / merge operate on the word currently presented by memory.
   always_comb begin
      rd_byte = mem_rdata[7:0];
      case (req_q.addr[1:0])
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         2'd3:    rd_byte = mem_rdata[31:24];
         default: rd_byte = mem_rdata[7:0];
      endcase
      rd_half = req_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      load_ext = mem_rdata;
      case (req_q.size)
         2'b00:   load_ext = {{24{req_q.sign & rd_byte[7]}}, rd_byte};
         2'b01:   load_ext = {{16{req_q.sign & rd_half[15]}}, rd_half};
         default: load_ext = mem_rdata;
      endcase

      merged = mem_rdata;
      if (req_q.size == 2'b00) begin
         case (req_q.addr[1:0])
            2'd0:    merged[7:0]   = req_q.wdata[7:0];
            2'd1:    merged[15:8]  = req_q.wdata[7:0];
            2'd2:    merged[23:16] = req_q.wdata[7:0];
            default: merged[31:24] = req_q.wdata[7:0];
         endcase
      end else if (req_q.addr[1]) begin
         merged[31:16] = req_q.wdata[15:0];
      end else begin
         merged[15:0] = req_q.wdata[15:0];
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (misaligned)                         state_nxt = RESP;
               else if (req_we && req_size == 2'b10)   state_nxt = WRITE;
               else                                    state_nxt = READ;
            end
         end
         READ: begin
            mem_addr  = {req_q.addr[31:2], 2'b00};
            state_nxt = req_q.we ? WRITE : RESP;
         end
         WRITE: begin
            mem_addr  = {req_q.addr[31:2], 2'b00};
            mem_we    = 1'b1;
            mem_wdata = req_q.wdata;
            state_nxt = RESP;
         end
         default: begin
            resp_valid = 1'b1;
            state_nxt  = IDLE;
         end
      endcase
   end

   assign mem_pc = req_q.pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // resp_* only change on the edge entering RESP so they hold between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q      <= '0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q <= '{addr: req_addr, wdata: req_wdata, pc: req_pc,
                             size: req_size, sign: req_sign, we: req_we};
                  if (misaligned) begin
                     resp_rdata <= 32'd0;
                     resp_err   <= 1'b1;
                  end
               end
            end
            READ: begin
               if (req_q.we) begin
                  req_q.wdata <= merged;
               end else begin
                  resp_rdata <= load_ext;
                  resp_err   <= 1'b0;
               end
            end
            WRITE: begin
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, queue-based reference of responses
// and memory writes (with due cycles), directed literal checks plus random traffic.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_sign = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [31:0] req_pc = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_pc;
   logic [31:0] mem_rdata;

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_pc(mem_pc), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Environment memory: combinational read, write on rising edge.
   logic [31:0] mem [0:4095];
   logic        mem_clr = 1'b1;
   assign mem_rdata = mem[mem_addr[13:2]];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      end else if (mem_we) begin
         mem[mem_addr[13:2]] <= mem_wdata;
      end
   end

   typedef struct { int due; logic [31:0] rdata; logic err; } rsp_t;
   typedef struct { int due; logic [31:0] addr; logic [31:0] data; logic [31:0] pc; } wr_t;

   rsp_t        rq[$];
   wr_t         wq[$];
   logic [31:0] ref_mem [0:4095];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit ref_mis(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                            input logic sign, input logic [31:0] addr);
      logic [31:0] v;
      if (size == 2'd0) begin
         v = (word >> (8 * addr[1:0])) & 32'hFF;
         if (sign && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (size == 2'd1) begin
         v = (word >> (16 * addr[1])) & 32'hFFFF;
         if (sign && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                             input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      if (size == 2'd2) return wd;
      sh   = (size == 2'd0) ? 8 * addr[1:0] : 16 * addr[1];
      mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Per-cycle compare against the queued expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         bit ev, ew;
         ev = (rq.size() > 0) && (rq[0].due == cyc);
         chk("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
         if (ev) begin
            chk("resp_rdata", resp_rdata, rq[0].rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, rq[0].err});
            void'(rq.pop_front());
         end
         ew = (wq.size() > 0) && (wq[0].due == cyc);
         chk("mem_we", {31'd0, mem_we}, {31'd0, ew});
         if (ew) begin
            chk("mem_addr", mem_addr, wq[0].addr);
            chk("mem_wdata", mem_wdata, wq[0].data);
            chk("mem_pc", mem_pc, wq[0].pc);
            void'(wq.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input bit hold);
      int          waitc;
      int          lat;
      bit          mis;
      logic [31:0] idx, nw;
      rsp_t        r;
      wr_t         w;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
      req_addr = addr; req_wdata = wdata; req_pc = pc;
      waitc = 0;
      while (!req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", waitc);
         req_valid = 1'b0;
         return;
      end
      mis = ref_mis(size, addr);
      idx = {20'd0, addr[13:2]};
      lat = mis ? 0 : ((!we || size == 2'd2) ? 1 : 2);
      r.due   = cyc + 1 + lat;
      r.err   = mis;
      r.rdata = (mis || we) ? 32'd0 : ref_load(ref_mem[idx], size, sign, addr);
      rq.push_back(r);
      if (we && !mis) begin
         nw = ref_store(ref_mem[idx], size, addr, wdata);
         w.due = cyc + 1 + lat - 1; w.addr = {addr[31:2], 2'b00}; w.data = nw; w.pc = pc;
         wq.push_back(w);
         ref_mem[idx] = nw;
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
      idle(3);
      // Reset state
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_pc", mem_pc, 32'd0);
      mem_clr = 1'b0;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Word store then load
      send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h100, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("ws_latency_resp", {31'd0, resp_valid}, 32'd1);
      send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h104, 1'b0);
      idle(3);
      chk("lw_deadbeef", resp_rdata, 32'hDEADBEEF);

      // Byte store RMW
      send(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h108, 1'b0);
      idle(2);
      send(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 32'h2222, 1'b0);
      @(negedge clk);
      chk("sb_read_no_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      chk("sb_write_we", {31'd0, mem_we}, 32'd1);
      chk("sb_mem_pc", mem_pc, 32'h2222);
      idle(2);
      chk("sb_mem_word", mem[8], 32'h11AA3344);

      // Load extension
      send(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F07F01, 32'h10C, 1'b0);
      idle(2);
      send(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 32'h110, 1'b0); idle(3);
      chk("lb_signed", resp_rdata, 32'hFFFFFF80);
      send(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, 32'h114, 1'b0); idle(3);
      chk("lbu", resp_rdata, 32'h00000080);
      send(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 32'h118, 1'b0); idle(3);
      chk("lh_lo", resp_rdata, 32'h00007F01);
      send(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 32'h11C, 1'b0); idle(3);
      chk("lh_hi", resp_rdata, 32'hFFFF80F0);

      // Misalignment
      send(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h120, 1'b0);
      @(negedge clk);
      chk("mis_lw_valid", {31'd0, resp_valid}, 32'd1);
      chk("mis_lw_err", {31'd0, resp_err}, 32'd1);
      chk("mis_lw_rdata", resp_rdata, 32'd0);
      send(1'b1, 2'd1, 1'b0, 32'h43, 32'h5555, 32'h124, 1'b0);
      @(negedge clk);
      chk("mis_sh_err", {31'd0, resp_err}, 32'd1);
      send(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h128, 1'b0);
      @(negedge clk);
      chk("mis_sz3_err", {31'd0, resp_err}, 32'd1);
      idle(2);

      // Handshake with req_valid held high across three requests
      send(1'b1, 2'd1, 1'b0, 32'h36, 32'h0000BEEF, 32'h130, 1'b1);
      send(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 32'h134, 1'b1);
      send(1'b0, 2'd0, 1'b1, 32'h37, 32'h0, 32'h138, 1'b0);
      idle(4);
      chk("hs_last_load", resp_rdata, 32'hFFFFFFBE);
      chk("hs_queue_empty", rq.size(), 32'd0);

      // Reset mid-WRITE
      send(1'b1, 2'd2, 1'b0, 32'h50, 32'h12345678, 32'h140, 1'b0);
      idle(3);
      chk_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h50;
      req_wdata = 32'hCAFEF00D; req_pc = 32'h144;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mid_write_we", {31'd0, mem_we}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_drops_we", {31'd0, mem_we}, 32'd0);
      chk("rst_drops_addr", mem_addr, 32'd0);
      @(negedge clk);
      chk("rst2_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst2_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst2_mem_pc", mem_pc, 32'd0);
      chk("rst2_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rst2_mem_unchanged", mem[20], 32'h12345678);
      chk_en = 1'b1;

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         bit hold;
         a = {24'd0, 8'($urandom_range(0, 255))};
         hold = 1'($urandom_range(0, 1));
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, $urandom, hold);
         if (!hold) idle($urandom_range(0, 2));
      end
      req_valid = 1'b0;
      idle(5);
      chk("final_rq_empty", rq.size(), 32'd0);
      chk("final_wq_empty", wq.size(), 32'd0);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
         chk("final_mem_image", bad, 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store unit that sits between the pipeline's MEM stage and the word-addressed data memory. It accepts one byte, halfword or word request at a time over a valid/ready handshake and turns it into word-only memory cycles, doing read-modify-write for sub-word stores. It sign- or zero-extends load data and flags misaligned accesses without touching memory. The memory it drives has a combinational word read, a write on the rising clock edge, and indexes with address bits [13:2].

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (treated as misaligned)
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_pc  in  32  instruction PC, forwarded to memory for the write trace
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned or illegal size
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}); 0 when idle
- mem_we  out  1  memory write enable
- mem_wdata  out  32  full word to write
- mem_pc  out  32  latched req_pc
- mem_rdata  in  32  combinational memory read data for mem_addr

## Operation
- States: IDLE, READ, WRITE, RESP.
- Requests are accepted on the edge where req_valid && req_ready. On acceptance the unit latches addr, wdata, size, sign, we and pc.
- Misaligned means any of:
  - size = 01 with addr[0] = 1
  - size = 10 with addr[1:0] != 0
  - size = 11
- Transitions from IDLE on acceptance:
  - misaligned -> RESP with err = 1; no memory cycle
  - word store -> WRITE
  - load or sub-word store -> READ
- READ: mem_we = 0 and mem_addr is driven. At the clock edge the unit captures mem_rdata.
  - Load: extract the lane, extend it into the result register, go to RESP.
  - Sub-word store: merge the store data into the captured word, go to WRITE.
- Lane selection is little-endian:
  - byte lane = addr[1:0]; byte k occupies bits [8k+7:8k]
  - half lane = addr[1]; half 0 is [15:0], half 1 is [31:16]
- Merge rule:
  - byte store replaces only the selected byte with wdata[7:0]
  - half store replaces only the selected half with wdata[15:0]
  - all other bits keep the value read
- WRITE: mem_we = 1, mem_wdata = merged word (or wdata for word stores), mem_pc = latched pc. The memory commits at the next edge, then the unit goes to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold their values until the next RESP overwrites them.
- mem_we, mem_addr, mem_wdata and mem_pc are decoded from state and latched registers. mem_addr is 0 in IDLE and RESP.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE, all latched registers = 0
  - req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_pc = 0
- Let accept edge = edge A; resp_valid is high in the cycle after the listed edge:
  - misaligned: A
  - load: A+1
  - word store: A+1 (memory written at edge A+1)
  - sub-word store: A+2 (read captured at A+1, written at A+2)
- Back-to-back: req_ready goes high in the cycle after the RESP cycle. The minimum request spacing is therefore response latency + 1.
- req_valid while busy is ignored and not latched. The requester must hold its request until req_ready is high.
- Reset asserted mid-operation:
  - mem_we drops immediately, so an in-flight WRITE does not commit
  - no resp_valid is produced for the aborted request
- Load-after-store to the same word returns the stored data, because the store commits before the load's READ state begins.

## Test plan
- Reset: hold rst_n = 0 mid-WRITE -> mem_we = 0 at once; after release req_ready = 1, all outputs 0, memory word unchanged.
- Word store then load: store 0xDEADBEEF to 0x00000010, then load word from 0x10 -> resp_rdata = 0xDEADBEEF; store resp_valid is high 1 cycle after the accept edge.
- Byte store RMW: word at 0x20 = 0x11223344; store byte 0xAA to 0x22 -> memory word = 0x11AA3344, written 2 edges after accept; mem_pc equals the request pc.
- Load extension, word at 0x30 = 0x80F07F01:
  - signed byte @0x33 -> 0xFFFFFF80
  - unsigned byte @0x33 -> 0x00000080
  - signed half @0x30 -> 0x00007F01
  - signed half @0x32 -> 0xFFFF80F0
- Misalignment: word load @0x41, half store @0x43, size = 11 -> each gives resp_err = 1 with resp_rdata = 0, one cycle after accept, and mem_we never asserts.
- Handshake: hold req_valid high continuously with 3 different requests -> exactly one accept per IDLE cycle, no request dropped or duplicated, responses in order.
